burst_split: RTL and testbench
==============================

// Module: burst_split
//
// PURPOSE
// - Expander, the inverse of the accumulator: one request handshake produces a
//   burst of p_nmsgs response handshakes.
// - Request carries {step, base}. Response i (i = 0..p_nmsgs-1) is
//   base + i*step, modulo 2^p_width.
// - Single-clock producer that feeds accumulator-style consumers: test
//   sources, address/index streams.
//
// PARAMETERS
// - p_width        4                    width of base, step and each response message
// - p_nmsgs        4                    responses per request; legal range >= 1
// - c_cnt_width    $clog2(p_nmsgs+1)    derived beat-counter width; never set from outside
//
// PORTS
// - clk        in   1            single clock; all state updates on posedge clk
// - reset      in   1            asynchronous, active-high reset
// - req_val    in   1            request valid
// - req_rdy    out  1            request ready
// - req_msg    in   2*p_width    [2*p_width-1:p_width] = step, [p_width-1:0] = base
// - resp_val   out  1            response valid
// - resp_rdy   in   1            response ready
// - resp_msg   out  p_width      current burst element
// - resp_last  out  1            only with BURST_SPLIT_LAST_EN; high on beat p_nmsgs-1
//
// BEHAVIOUR
// - Handshakes
//   - req_go  = req_val & req_rdy
//   - resp_go = resp_val & resp_rdy
// - Registers: cur (p_width), step_r (p_width), cnt (c_cnt_width), state.
// - States: IDLE, BUSY. State, cnt, cur, step_r all reset to 0/IDLE.
// - Outputs during reset: req_rdy=1, resp_val=0, resp_msg=0, resp_last=0.
// - IDLE
//   - req_rdy=1, resp_val=0.
//   - On req_go: cur<=base, step_r<=step, cnt<=0, go BUSY.
// - BUSY
//   - resp_val=1, resp_msg=cur. Output is registered: no combinational path
//     from req_msg to resp_msg.
//   - resp_go with cnt != p_nmsgs-1: cur<=cur+step_r (wraps), cnt<=cnt+1.
//   - No resp_go: all state holds; resp_msg is stable while resp_val & !resp_rdy.
// - Last beat (cnt == p_nmsgs-1)
//   - req_rdy = resp_rdy, a combinational pipeline path.
//   - resp_go & req_val: load the new request; stay BUSY.
//   - resp_go & !req_val: go IDLE.
// - Latency and throughput
//   - First response valid the cycle after req_go.
//   - Back-to-back bursts run at full rate: p_nmsgs responses every p_nmsgs
//     cycles under continuous resp_rdy.
// - p_nmsgs == 1: every beat is the last beat. Block acts as a 1-deep pipeline
//   register passing base through.
// - Arithmetic: unsigned add, truncated to p_width, no saturation.
//   Example: p_width=4, base=14, step=3 -> 14, 1, 4, 7.
// - req_val while BUSY and not on the last beat: req_rdy=0, request not consumed.
// - Reset asserted mid-burst: the in-flight burst is dropped immediately
//   (async). resp_val falls without waiting for a clock edge. After deassertion
//   the block is IDLE.
//
// CONFIGURATION
// - BURST_SPLIT_LAST_EN defined
//   - resp_last port exists: resp_last = BUSY & (cnt == p_nmsgs-1).
//   - Reset value 0. Valid only when qualified by resp_val.
// - BURST_SPLIT_LAST_EN undefined
//   - Port and logic absent. All other behaviour identical.
//
// TESTING
// - p_width=4, p_nmsgs=4, req {step=1, base=2}, resp_rdy=1 -> resp 2,3,4,5 on
//   4 consecutive cycles, then resp_val=0.
// - Wrap-around: req {step=3, base=14} -> 14, 1, 4, 7; resp_last=1 only on 7
//   when BURST_SPLIT_LAST_EN is defined.
// - Backpressure: drop resp_rdy for 3 cycles mid-burst -> resp_msg held, no beat
//   lost or duplicated, req_rdy=0.
// - Back-to-back: req_val high with {1,0} then {2,8} -> 0,1,2,3,8,10,12,14 in
//   8 consecutive cycles; second req_go coincides with the beat-3 resp_go.
// - Reset mid-burst: assert reset after beat 1 -> resp_val=0 in the same cycle;
//   after release, req {0,5} -> 5,5,5,5.
// - p_nmsgs=1: stream of requests with bases 7, 9, 11 -> resp 7, 9, 11 at one
//   per cycle.

Source files
------------

// File: rtl/burst_split.sv
// Burst expander: one {step, base} request yields p_nmsgs responses base + i*step.
// Optional resp_last output is enabled by defining BURST_SPLIT_LAST_EN.

module burst_split #(
  parameter int unsigned p_width = 4,
  parameter int unsigned p_nmsgs = 4
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [2*p_width-1:0] req_msg,

  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [p_width-1:0]   resp_msg
`ifdef BURST_SPLIT_LAST_EN
  ,
  output logic                 resp_last
`endif
);

  localparam int unsigned c_cnt_width = $clog2(p_nmsgs + 1);
  localparam logic [c_cnt_width-1:0] LastCnt = c_cnt_width'(p_nmsgs - 1);

  if (p_nmsgs < 1) begin : g_bad_nmsgs
    $error("burst_split: p_nmsgs must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [p_width-1:0]     cur_q, cur_d;
  logic [p_width-1:0]     step_q, step_d;
  logic [c_cnt_width-1:0] cnt_q, cnt_d;

  logic               busy;
  logic               last_beat;
  logic               req_go;
  logic               resp_go;
  logic [p_width-1:0] req_step;
  logic [p_width-1:0] req_base;

  assign req_step = req_msg[2*p_width-1:p_width];
  assign req_base = req_msg[p_width-1:0];

  assign busy      = (state_q == StBusy);
  assign last_beat = busy && (cnt_q == LastCnt);

  // On the last beat a new request is accepted exactly when the final beat
  // drains, keeping back-to-back bursts at full rate.
  assign req_rdy  = !busy || (last_beat && resp_rdy);
  assign resp_val = busy;
  assign resp_msg = cur_q;

  assign req_go  = req_val && req_rdy;
  assign resp_go = resp_val && resp_rdy;

`ifdef BURST_SPLIT_LAST_EN
  assign resp_last = last_beat;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    step_d  = step_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: ;
      StBusy: begin
        if (resp_go) begin
          if (!last_beat) begin
            cur_d = cur_q + step_q;
            cnt_d = cnt_q + c_cnt_width'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A load overrides both the idle hold and the last-beat drain.
    if (req_go) begin
      state_d = StBusy;
      cur_d   = req_base;
      step_d  = req_step;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_burst_split.sv
// Directed bench for burst_split: per-cycle vector table on a 4-beat instance,
// plus a hand-written stream through a 1-beat instance.

module tb_burst_split;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       req_val = 1'b0;
  logic       req_rdy;
  logic [7:0] req_msg = '0;
  logic       resp_val;
  logic       resp_rdy = 1'b0;
  logic [3:0] resp_msg;
  logic       resp_last;

  logic       b_req_val = 1'b0;
  logic       b_req_rdy;
  logic [7:0] b_req_msg = '0;
  logic       b_resp_val;
  logic       b_resp_rdy = 1'b0;
  logic [3:0] b_resp_msg;
  logic       b_resp_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_split #(.p_width(4), .p_nmsgs(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
`ifdef BURST_SPLIT_LAST_EN
    ,
    .resp_last(resp_last)
`endif
  );

  burst_split #(.p_width(4), .p_nmsgs(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .req_val  (b_req_val),
    .req_rdy  (b_req_rdy),
    .req_msg  (b_req_msg),
    .resp_val (b_resp_val),
    .resp_rdy (b_resp_rdy),
    .resp_msg (b_resp_msg)
`ifdef BURST_SPLIT_LAST_EN
    ,
    .resp_last(b_resp_last)
`endif
  );

`ifndef BURST_SPLIT_LAST_EN
  assign resp_last   = 1'b0;
  assign b_resp_last = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       rv;
    logic [3:0] step;
    logic [3:0] base;
    logic       rr;
    logic       e_rdy;
    logic       e_val;
    logic [3:0] e_msg;
    logic       e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, input logic rv, input logic [3:0] step,
                     input logic [3:0] base, input logic rr, input logic e_rdy,
                     input logic e_val, input logic [3:0] e_msg, input logic e_last);
    vec_t v;
    v.rst = rst; v.rv = rv; v.step = step; v.base = base; v.rr = rr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_msg = e_msg; v.e_last = e_last;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // row(rst, rv, step, base, rr, e_rdy, e_val, e_msg, e_last)
    row(1, 0, 0, 0, 0, 1, 0, 0, 0);        // in reset
    // basic burst {1,2}
    row(0, 1, 1, 2, 1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 2, 0);
    row(0, 0, 0, 0, 1, 0, 1, 3, 0);
    row(0, 0, 0, 0, 1, 0, 1, 4, 0);
    row(0, 0, 0, 0, 1, 1, 1, 5, 1);
    // wrap-around {3,14}
    row(0, 1, 3, 14, 1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 14, 0);
    row(0, 0, 0, 0, 1, 0, 1, 1, 0);
    row(0, 0, 0, 0, 1, 0, 1, 4, 0);
    row(0, 0, 0, 0, 1, 1, 1, 7, 1);
    // backpressure {2,0}, stalled while a new request waits
    row(0, 1, 2, 0, 1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 0, 0);
    row(0, 1, 5, 5, 0, 0, 1, 2, 0);
    row(0, 1, 5, 5, 0, 0, 1, 2, 0);
    row(0, 1, 5, 5, 0, 0, 1, 2, 0);
    row(0, 0, 0, 0, 1, 0, 1, 2, 0);
    row(0, 0, 0, 0, 1, 0, 1, 4, 0);
    row(0, 0, 0, 0, 1, 1, 1, 6, 1);
    row(0, 0, 0, 0, 1, 1, 0, 0, 0);
    // back-to-back {1,0} then {2,8}
    row(0, 1, 1, 0, 1, 1, 0, 0, 0);
    row(0, 1, 2, 8, 1, 0, 1, 0, 0);
    row(0, 1, 2, 8, 1, 0, 1, 1, 0);
    row(0, 1, 2, 8, 1, 0, 1, 2, 0);
    row(0, 1, 2, 8, 1, 1, 1, 3, 1);
    row(0, 0, 0, 0, 1, 0, 1, 8, 0);
    row(0, 0, 0, 0, 1, 0, 1, 10, 0);
    row(0, 0, 0, 0, 1, 0, 1, 12, 0);
    row(0, 0, 0, 0, 1, 1, 1, 14, 1);
    // last beat stalled: req_rdy follows resp_rdy
    row(0, 1, 1, 1, 1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 1, 0);
    row(0, 0, 0, 0, 1, 0, 1, 2, 0);
    row(0, 0, 0, 0, 1, 0, 1, 3, 0);
    row(0, 1, 0, 9, 0, 0, 1, 4, 1);
    row(0, 1, 0, 9, 1, 1, 1, 4, 1);
    row(0, 0, 0, 0, 1, 0, 1, 9, 0);
    row(0, 0, 0, 0, 1, 0, 1, 9, 0);
    row(0, 0, 0, 0, 1, 0, 1, 9, 0);
    row(0, 0, 0, 0, 1, 1, 1, 9, 1);
    // reset mid-burst after beat 1, then {0,5}
    row(0, 1, 4, 1, 1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 1, 0);
    row(0, 0, 0, 0, 1, 0, 1, 5, 0);
    row(1, 0, 0, 0, 1, 1, 0, 0, 0);
    row(0, 1, 0, 5, 1, 1, 0, 0, 0);
    row(0, 0, 0, 0, 1, 0, 1, 5, 0);
    row(0, 0, 0, 0, 1, 0, 1, 5, 0);
    row(0, 0, 0, 0, 1, 0, 1, 5, 0);
    row(0, 0, 0, 0, 1, 1, 1, 5, 1);
    row(0, 0, 0, 0, 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset    = vecs[i].rst;
      req_val  = vecs[i].rv;
      req_msg  = {vecs[i].step, vecs[i].base};
      resp_rdy = vecs[i].rr;
      #1;
      check($sformatf("row%0d resp_val", i), resp_val, vecs[i].e_val);
      check($sformatf("row%0d req_rdy", i), req_rdy, vecs[i].e_rdy);
      if (vecs[i].e_val || vecs[i].rst)
        check($sformatf("row%0d resp_msg", i), resp_msg, vecs[i].e_msg);
`ifdef BURST_SPLIT_LAST_EN
      if (vecs[i].e_val || vecs[i].rst)
        check($sformatf("row%0d resp_last", i), resp_last, vecs[i].e_last);
`endif
    end

    // p_nmsgs == 1: a one-deep pipeline passing base through
    @(negedge clk);
    req_val    = 1'b0;
    b_resp_rdy = 1'b1;
    b_req_val  = 1'b1;
    b_req_msg  = {4'd1, 4'd7};
    #1;
    check("n1 idle resp_val", b_resp_val, 0);
    check("n1 idle req_rdy", b_req_rdy, 1);
    @(negedge clk);
    b_req_msg = {4'd1, 4'd9};
    #1;
    check("n1 beat0 resp_val", b_resp_val, 1);
    check("n1 beat0 resp_msg", b_resp_msg, 7);
    check("n1 beat0 req_rdy", b_req_rdy, 1);
`ifdef BURST_SPLIT_LAST_EN
    check("n1 beat0 resp_last", b_resp_last, 1);
`endif
    @(negedge clk);
    b_req_msg = {4'd1, 4'd11};
    #1;
    check("n1 beat1 resp_val", b_resp_val, 1);
    check("n1 beat1 resp_msg", b_resp_msg, 9);
    @(negedge clk);
    b_req_val = 1'b0;
    #1;
    check("n1 beat2 resp_val", b_resp_val, 1);
    check("n1 beat2 resp_msg", b_resp_msg, 11);
    check("n1 beat2 req_rdy", b_req_rdy, 1);
    @(negedge clk);
    #1;
    check("n1 drained resp_val", b_resp_val, 0);

    // stalled single beat: req_rdy drops with resp_rdy
    b_req_val = 1'b1;
    b_req_msg = {4'd0, 4'd3};
    @(negedge clk);
    b_resp_rdy = 1'b0;
    b_req_msg  = {4'd0, 4'd4};
    #1;
    check("n1 stall req_rdy", b_req_rdy, 0);
    check("n1 stall resp_msg", b_resp_msg, 3);
    @(negedge clk);
    #1;
    check("n1 stall hold resp_msg", b_resp_msg, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
